// File: rtl/paddle_autopilot_pkg.sv
// Shared display geometry, key encodings and FSM state type for the pong
// computer player.
package paddle_autopilot_pkg;

  // Display geometry shared with the rest of the pong game.
  localparam logic [9:0] V_DISP = 10'd480;
  localparam logic [9:0] SLDE_W = 10'd10;
  localparam logic [9:0] BODY_L = 10'd80;

  // Paddle key encoding, identical to the push-button path.
  localparam logic [1:0] KEY_HOLD = 2'b11;
  localparam logic [1:0] KEY_DOWN = 2'b10;
  localparam logic [1:0] KEY_UP   = 2'b01;

  localparam int ERR_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_TRACK  = 2'd2,
    ST_RETURN = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [ERR_W-1:0] err;
    logic        [ERR_W-1:0] mag;
    logic                    neg;
    logic                    zero;
  } err_t;

  function automatic logic [1:0] dir_key(input logic down);
    return down ? KEY_DOWN : KEY_UP;
  endfunction

endpackage

// File: rtl/paddle_autopilot_track_err.sv
// Paddle position error against either the ball centre or the screen centre,
// with magnitude and sign ready for the motion rules.
module paddle_autopilot_track_err
  import paddle_autopilot_pkg::*;
#(
  parameter logic [9:0] BALL_H = 10'd20
) (
  input  logic [9:0] ball_y_i,
  input  logic [9:0] body_y_i,
  input  logic       centre_i,
  output err_t       res_o
);

  localparam logic signed [ERR_W-1:0] HALF_BALL = $signed({2'b00, BALL_H >> 1});
  localparam logic signed [ERR_W-1:0] HALF_BODY = $signed({2'b00, BODY_L >> 1});
  localparam logic signed [ERR_W-1:0] CENTRE_Y  = $signed({2'b00, (V_DISP - BODY_L) >> 1});

  logic signed [ERR_W-1:0] target;
  logic signed [ERR_W-1:0] err;
  logic signed [ERR_W-1:0] err_neg;

  // Zero-extended 10-bit operands keep every result inside 12-bit signed range.
  assign target  = centre_i ? CENTRE_Y
                            : $signed({2'b00, ball_y_i}) + HALF_BALL - HALF_BODY;
  assign err     = target - $signed({2'b00, body_y_i});
  assign err_neg = -err;

  assign res_o = '{
    err:  err,
    mag:  err[ERR_W-1] ? unsigned'(err_neg) : unsigned'(err),
    neg:  err[ERR_W-1],
    zero: (err == '0)
  };

endmodule

// File: rtl/paddle_autopilot.sv
// Computer-player paddle controller: reaction delay, hysteretic tracking of
// the ball and return-to-centre, producing the paddle's two-bit key once per frame.
module paddle_autopilot
  import paddle_autopilot_pkg::*;
#(
  parameter int         REACT_DLY = 6,
  parameter int         DEAD_ZONE = 8,
  parameter int         STOP_ZONE = 1,
  parameter logic [9:0] BALL_H    = 10'd20
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic       en,
  input  logic       tick,
  input  logic [9:0] ball_y,
  input  logic       ball_toward,
  input  logic [9:0] body_y,
  output logic [1:0] key,
  output logic       tracking
);

  localparam int                   CNT_W        = (REACT_DLY > 2) ? $clog2(REACT_DLY) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST     = (REACT_DLY > 1) ? CNT_W'(REACT_DLY - 1) : '0;
  localparam logic [ERR_W-1:0]     DEAD_MAG     = ERR_W'(DEAD_ZONE);
  localparam logic [ERR_W-1:0]     STOP_MAG     = ERR_W'(STOP_ZONE);
  localparam logic [9:0]           GUARD_DOWN_Y = V_DISP - SLDE_W - BODY_L;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             moving_q, moving_d;
  logic             dir_down_q, dir_down_d;
  logic [1:0]       key_q, key_d;
  logic             tracking_q;

  logic             moving_now;
  logic             dir_now;
  logic             wait_done;
  logic             wall_down;
  logic             wall_up;
  err_t             err_s;

  // Any tick that lands in TRACK/RETURN does so with ball_toward high/low
  // respectively, so the target choice needs no knowledge of the next state.
  paddle_autopilot_track_err #(
    .BALL_H (BALL_H)
  ) u_track_err (
    .ball_y_i (ball_y),
    .body_y_i (body_y),
    .centre_i (~ball_toward),
    .res_o    (err_s)
  );

  assign wait_done = (REACT_DLY <= 1) || (cnt_q == CNT_LAST);
  assign wall_down = (body_y >= GUARD_DOWN_Y);
  assign wall_up   = (body_y <= SLDE_W);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    moving_d   = moving_q;
    dir_down_d = dir_down_q;
    key_d      = key_q;
    moving_now = 1'b0;
    dir_now    = dir_down_q;

    if (!en) begin
      state_d  = ST_IDLE;
      moving_d = 1'b0;
      key_d    = KEY_HOLD;
    end else if (tick) begin
      key_d    = KEY_HOLD;
      moving_d = 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          state_d = ball_toward ? ST_WAIT : ST_RETURN;
        end
        ST_WAIT: begin
          if (!ball_toward)   state_d = ST_RETURN;
          else if (wait_done) state_d = ST_TRACK;
          else                cnt_d   = cnt_q + 1'b1;
        end
        ST_TRACK: begin
          if (!ball_toward) state_d = ST_RETURN;
        end
        ST_RETURN: begin
          if (ball_toward) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Entering a motion state starts from rest; staying keeps the hysteresis.
      if (state_d == ST_TRACK || state_d == ST_RETURN) begin
        moving_now = (state_d == state_q) && moving_q;
        if (!moving_now) begin
          if (err_s.mag > DEAD_MAG) begin
            moving_d = 1'b1;
            dir_now  = ~err_s.neg;
          end
        end else if (dir_down_q ? err_s.neg : (~err_s.neg && ~err_s.zero)) begin
          moving_d = 1'b0;
        end else if (err_s.mag <= STOP_MAG) begin
          moving_d = 1'b0;
        end else begin
          moving_d = 1'b1;
        end

        // The wall guard only masks the key; motion stays latched.
        if (moving_d && !(dir_now ? wall_down : wall_up)) begin
          key_d = dir_key(dir_now);
        end
        dir_down_d = dir_now;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      moving_q   <= 1'b0;
      dir_down_q <= 1'b0;
      key_q      <= KEY_HOLD;
      tracking_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      moving_q   <= moving_d;
      dir_down_q <= dir_down_d;
      key_q      <= key_d;
      tracking_q <= (state_d == ST_TRACK);
    end
  end

  assign key      = key_q;
  assign tracking = tracking_q;

endmodule

// File: tb/tb_paddle_autopilot.sv
// Self-checking bench for paddle_autopilot: a vector table of per-tick
// stimulus with expected key/tracking, plus hand sequences for disable and reset.
module tb_paddle_autopilot;

  logic       vga_clk = 1'b0;
  logic       sys_rst;
  logic       en;
  logic       tick;
  logic [9:0] ball_y;
  logic       ball_toward;
  logic [9:0] body_y;
  logic [1:0] key;
  logic       tracking;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic       toward;
    logic [9:0] ball_y;
    logic [9:0] body_y;
    logic [1:0] key;
    logic       trk;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] key;
    logic       trk;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  paddle_autopilot dut (
    .vga_clk     (vga_clk),
    .sys_rst     (sys_rst),
    .en          (en),
    .tick        (tick),
    .ball_y      (ball_y),
    .ball_toward (ball_toward),
    .body_y      (body_y),
    .key         (key),
    .tracking    (tracking)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input exp_t e);
    checks++;
    if (key !== e.key || tracking !== e.trk) begin
      failures++;
      $display("FAIL %s: key=%b tracking=%b, expected key=%b tracking=%b",
               e.name, key, tracking, e.key, e.trk);
    end
  endtask

  task automatic expect_now(input string name, input logic [1:0] k, input logic t);
    exp_t e;
    e.name = name;
    e.key  = k;
    e.trk  = t;
    sb.push_back(e);
  endtask

  task automatic pop_check(output exp_t e);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: queue empty, expected an entry");
      e.name = "none";
      e.key  = 2'b11;
      e.trk  = 1'b0;
    end else begin
      e = sb.pop_front();
      check(e);
    end
  endtask

  task automatic add(input logic e, input logic tw, input int by, input int py,
                     input logic [1:0] k, input logic t);
    vec_t v;
    v.en     = e;
    v.toward = tw;
    v.ball_y = 10'(by);
    v.body_y = 10'(py);
    v.key    = k;
    v.trk    = t;
    vecs.push_back(v);
  endtask

  // One frame: drive inputs with a tick, check the edge result, then check the
  // key has not moved two cycles later.
  task automatic do_tick(input vec_t v, input string name);
    exp_t e;
    @(negedge vga_clk);
    en          = v.en;
    ball_toward = v.toward;
    ball_y      = v.ball_y;
    body_y      = v.body_y;
    tick        = 1'b1;
    expect_now(name, v.key, v.trk);
    @(negedge vga_clk);
    tick = 1'b0;
    pop_check(e);
    repeat (2) @(negedge vga_clk);
    e.name = {name, "_hold"};
    check(e);
  endtask

  initial begin
    exp_t e;
    vec_t v;

    // Reach WAIT then TRACK: ball 300 / body 200 gives err=+70.
    for (int i = 0; i < 6; i++) add(1, 1, 300, 200, 2'b11, 0);
    add(1, 1, 300, 200, 2'b10, 1);  // 7th tick: TRACK, moving down
    add(1, 1, 300, 269, 2'b11, 1);  // err +1: stop
    add(1, 1, 300, 264, 2'b11, 1);  // err +6: inside dead zone
    add(1, 1, 300, 261, 2'b10, 1);  // err +9: start down
    add(1, 1, 300, 266, 2'b10, 1);  // err +4: keep moving
    add(1, 1, 300, 269, 2'b11, 1);  // err +1: stop
    add(1, 1, 300, 200, 2'b10, 1);  // err +70: start down
    add(1, 1, 300, 290, 2'b11, 1);  // err -20: reversal hold
    add(1, 1, 300, 290, 2'b01, 1);  // restart up
    add(1, 1, 470, 390, 2'b11, 1);  // err +50 while up: reversal hold
    add(1, 1, 470, 390, 2'b11, 1);  // start down, bottom wall guard
    add(1, 1, 425, 390, 2'b11, 1);  // err +5, still guarded, motion latched
    add(1, 1, 423, 388, 2'b10, 1);  // err +5 off the wall: moves (latched)
    add(1, 0, 423,  10, 2'b10, 0);  // RETURN, centre err +190
    add(1, 0, 423, 100, 2'b10, 0);
    add(1, 0, 423, 198, 2'b10, 0);  // err +2
    add(1, 0, 423, 199, 2'b11, 0);  // err +1: stop
    for (int i = 0; i < 6; i++) add(1, 1, 0, 10, 2'b11, 0);  // WAIT, counter restarted
    add(1, 1,   0,  10, 2'b11, 1);  // TRACK, err -40 up, top wall guard
    add(1, 1,   0,  11, 2'b01, 1);  // off the wall: up
    add(0, 1,   0,  11, 2'b11, 0);  // disable with tick while key=01
    add(1, 0,   0,  11, 2'b10, 0);  // IDLE -> RETURN, err +189

    sys_rst     = 1'b1;
    en          = 1'b0;
    tick        = 1'b0;
    ball_toward = 1'b0;
    ball_y      = '0;
    body_y      = '0;
    repeat (3) @(negedge vga_clk);
    sys_rst = 1'b0;
    expect_now("reset_state", 2'b11, 1'b0);
    @(negedge vga_clk);
    pop_check(e);

    for (int i = 0; i < vecs.size(); i++) begin
      do_tick(vecs[i], $sformatf("vec%0d", i));
    end

    // Disable without a tick while moving.
    @(negedge vga_clk);
    en = 1'b0;
    expect_now("disable_no_tick", 2'b11, 1'b0);
    @(negedge vga_clk);
    pop_check(e);
    en = 1'b1;

    // ball_toward falling during WAIT goes straight to RETURN in that tick.
    v = '{en: 1'b1, toward: 1'b1, ball_y: 10'd0, body_y: 10'd11, key: 2'b11, trk: 1'b0};
    do_tick(v, "idle_to_wait");
    v = '{en: 1'b1, toward: 1'b0, ball_y: 10'd0, body_y: 10'd11, key: 2'b10, trk: 1'b0};
    do_tick(v, "wait_to_return");

    // Reset mid-motion, coincident with tick and en: reset wins.
    @(negedge vga_clk);
    sys_rst = 1'b1;
    tick    = 1'b1;
    expect_now("reset_mid_motion", 2'b11, 1'b0);
    @(negedge vga_clk);
    sys_rst = 1'b0;
    tick    = 1'b0;
    pop_check(e);
    expect_now("reset_hold", 2'b11, 1'b0);
    @(negedge vga_clk);
    pop_check(e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paddle_autopilot.md
# paddle_autopilot

Computer-player controller for the pong game. It samples the ball and paddle positions once per frame tick and drives the paddle's two-bit `key` input. It uses the same encoding as the push-button path, so a paddle module can be fed by either a player or this block through a mux. Tracking uses a reaction delay, a dead zone with hysteresis, and a return-to-centre behaviour while the ball moves away.

## Interface
Parameters:
- `REACT_DLY`, 6: frame ticks between the ball turning toward this paddle and the start of tracking.
- `DEAD_ZONE`, 8: |error| in pixels above which motion starts.
- `STOP_ZONE`, 1: |error| in pixels at or below which motion stops. Must be less than `DEAD_ZONE`.
- `BALL_H`, 10'd20: ball height in pixels.

Ports:
- `vga_clk`, in, 1: system clock, the only clock.
- `sys_rst`, in, 1: reset, synchronous, active-high.
- `en`, in, 1: autopilot enable. 0 forces idle.
- `tick`, in, 1: one-cycle frame strobe; all decisions happen on it.
- `ball_y`, in, 10: ball top-left y.
- `ball_toward`, in, 1: 1 = ball horizontal velocity points at this paddle.
- `body_y`, in, 10: paddle top-left y.
- `key`, out, 2: registered. 2'b11 = hold, 2'b10 = down (y+), 2'b01 = up (y−). 2'b00 is never driven.
- `tracking`, out, 1: registered; 1 while in TRACK.

## Operation
- **Error computation**
  - target = `ball_y` + `BALL_H`/2 − `body_l`/2 while tracking.
  - target = (`V_DISP` − `body_l`)/2 in RETURN.
  - err = target − `body_y`, computed as 12-bit signed with zero-extended operands; no wrap is possible.
- **States:** IDLE, WAIT, TRACK, RETURN.
- **IDLE**
  - `key`=11.
  - On `tick` with `en`=1: if `ball_toward` → WAIT with delay counter cleared, else → RETURN.
- **WAIT**
  - `key`=11.
  - Counter increments per `tick`. When the counter reaches `REACT_DLY`−1 on a `tick` → TRACK.
  - If `ball_toward` falls → RETURN.
- **TRACK and RETURN** share a motion sub-state `moving` with hysteresis:
  - Start rule: if not moving and |err| > `DEAD_ZONE`, set `moving` and set direction = sign(err).
  - Stop rule: if moving and |err| ≤ `STOP_ZONE`, clear `moving`.
  - Reversal: if moving and sign(err) disagrees with the stored direction, drive `key`=11 for that tick and clear `moving`. Motion restarts only under the start rule.
  - Wall guard, down: when direction is down and `body_y` ≥ `V_DISP`−`SLDE_W`−`body_l`, output 11.
  - Wall guard, up: when direction is up and `body_y` ≤ `SLDE_W`, output 11.
  - The wall guard does not clear `moving`.
- **TRACK exits:** `ball_toward` falling → RETURN.
- **RETURN exits:** `ball_toward` rising → WAIT with counter cleared.
- **Disable:** `en`=0 in any state → IDLE on the next clock, regardless of `tick`. `moving` is cleared and `key`=11.
- **Outputs between ticks:** `key` holds its last value. The paddle samples `key` on its own move strobe, so `key` must stay stable across a whole frame.

## Timing
- Reset values: state IDLE, counter 0, `moving` 0, `key`=2'b11, `tracking`=0.
- Latency: `key` and `tracking` update on the clock edge that samples `tick`=1. Effect is visible 1 cycle after `tick`.
- `sys_rst` has priority over `en` and `tick`.
- Reset asserted mid-motion returns `key` to 11 on the next edge.
- `tick` coinciding with `en` falling: the disable wins.
- `tick` coinciding with a `ball_toward` change: the transition uses the new `ball_toward` value in that same tick.
- `REACT_DLY`=0 is legal: WAIT lasts exactly one tick.

## Structure
- Reuse `config.v` defines `V_DISP`, `SLDE_W`, `body_l`.
- Add to the shared config:
  - `KEY_HOLD`/`KEY_DOWN`/`KEY_UP` encodings.
  - The four state encodings, 2-bit.
- One natural sub-module: `track_err`, combinational target/err/|err|/sign computation, reused by TRACK and RETURN.
- Top contains the FSM, the delay counter and the output registers.

## Test plan
Expected values below use `V_DISP`=480, `SLDE_W`=10, `body_l`=80 and default parameters; recompute if `config.v` differs.
- Reset, then `en`=1, `ball_toward`=1, `tick` every 4 cycles:
  - `key`=11 for 6 ticks (WAIT), then TRACK asserted.
  - With `ball_y`=300, `body_y`=200 (err=+70) → `key`=10 one cycle after the 7th tick.
- Hysteresis:
  - In TRACK with err=+6 and not moving → `key` stays 11.
  - Step err to +9 → `key`=10.
  - Reduce err to +4 → still 10.
  - Reduce err to +1 → 11.
- Reversal: while moving down, force err to −20 → one tick of 11, then 01 on the following tick.
- Wall guard: `body_y`=390, err=+50 → `key`=11 with `moving` still 1. Drop `body_y` to 388 → 10 on the next tick.
- RETURN: `ball_toward`=0 with `body_y`=10 → `key`=10 until `body_y` is within 1 of 200, then 11.
- Disable and reset mid-motion:
  - `en`=0 coincident with `tick` while `key`=01 → `key`=11, state IDLE next cycle.
  - `sys_rst` pulse while moving → all outputs at reset values next edge.
